// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA constants (640x480@60 defaults), pixel type and
// colour-bar helper used by vga_timing_ctrl.
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int DEF_CW = 4;
  localparam bit POL_LOW = 1'b0;
  localparam bit POL_HIGH = 1'b1;
  typedef struct packed {
    logic [DEF_CW-1:0] b;
    logic [DEF_CW-1:0] g;
    logic [DEF_CW-1:0] r;
  } rgb_t;
  function automatic int unsigned bar_of(input int unsigned col, input int unsigned h_active);
    return col * 8 / h_active;
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage register pipeline with async active-low clear;
// DEPTH=0 is a plain wire.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             vga_clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  if (DEPTH == 0) begin : g_wire
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH*DEPTH-1:0] pipe_q, pipe_d;
    // newest entry sits in the LSBs, oldest at the top
    always_comb pipe_d = (WIDTH*DEPTH)'({pipe_q, din});
    always_ff @(posedge vga_clk or negedge clrn)
      if (!clrn) pipe_q <= '0;
      else pipe_q <= pipe_d;
    assign dout = pipe_q[WIDTH*DEPTH-1 -: WIDTH];
  end
endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing, frame-buffer read addressing and RGB/sync
// outputs aligned to RD_LAT read latency; VGA_TEST_PATTERN_EN adds pat_sel colour bars.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter bit HS_POL = POL_LOW,
  parameter bit VS_POL = POL_LOW,
  parameter int CW = DEF_CW,
  parameter int RD_LAT = 1,
  localparam int RW = $clog2(V_ACTIVE),
  localparam int CA = $clog2(H_ACTIVE)
) (
  input  logic          vga_clk,
  input  logic          clrn,
  input  logic [3*CW-1:0] d_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic          pat_sel,
`endif
  output logic [RW-1:0] row_addr,
  output logic [CA-1:0] col_addr,
  output logic          rdn,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic          frame_start,
  output logic          line_start
);
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int H_TOTAL = H_START + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_START + V_ACTIVE + V_FP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
`ifdef VGA_TEST_PATTERN_EN
  localparam int FW = 5 + CA;
`else
  localparam int FW = 5;
`endif
  logic [HW-1:0] h_cnt_q, h_cnt_d, h_off;
  logic [VW-1:0] v_cnt_q, v_cnt_d, v_off;
  logic h_end, v_end, act, pat_on;
  logic [RW-1:0] row_addr_q, row_addr_d;
  logic [CA-1:0] col_addr_q, col_addr_d;
  logic rdn_q, rdn_d;
  logic [4:0] st_q, st_d;
  logic [FW-1:0] dl_in, dl;
  logic [3*CW-1:0] pix_q, pix_d, pix_src;
  logic hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d, ls_q, ls_d;
`ifdef VGA_TEST_PATTERN_EN
  logic pat_q, pat_d;
  logic [2:0] bar_k;
  // pattern select only changes at the frame wrap, deep inside blanking
  always_comb begin
    pat_d = (h_end && v_end) ? pat_sel : pat_q;
    bar_k = 3'(bar_of(32'(dl[FW-1 -: CA]), H_ACTIVE));
    pix_src = pat_q ? {{CW{bar_k[2]}}, {CW{bar_k[1]}}, {CW{bar_k[0]}}} : d_in;
  end
  always_ff @(posedge vga_clk or negedge clrn)
    if (!clrn) pat_q <= 1'b0;
    else pat_q <= pat_d;
  assign pat_on = pat_q;
  assign dl_in = {col_addr_q, st_q};
`else
  assign pat_on = 1'b0;
  assign pix_src = d_in;
  assign dl_in = st_q;
`endif
  // offsets wrap to large values before the active window, so one compare per axis suffices
  always_comb begin
    h_end = h_cnt_q == HW'(H_TOTAL - 1);
    v_end = v_cnt_q == VW'(V_TOTAL - 1);
    h_cnt_d = h_end ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = !h_end ? v_cnt_q : v_end ? '0 : v_cnt_q + 1'b1;
    h_off = h_cnt_q - HW'(H_START);
    v_off = v_cnt_q - VW'(V_START);
    act = (h_off < HW'(H_ACTIVE)) && (v_off < VW'(V_ACTIVE));
    row_addr_d = v_off[RW-1:0];
    col_addr_d = h_off[CA-1:0];
    rdn_d = ~(act & ~pat_on);
    st_d = {act && h_off == '0 && v_off == '0, act && h_off == '0,
            v_cnt_q < VW'(V_SYNC), h_cnt_q < HW'(H_SYNC), act};
    de_d = dl[0];
    hs_d = dl[1] ^ ~HS_POL;
    vs_d = dl[2] ^ ~VS_POL;
    ls_d = dl[3];
    fs_d = dl[4];
    pix_d = dl[0] ? pix_src : '0;
  end
  vga_delay_line #(.WIDTH(FW), .DEPTH(RD_LAT)) u_dly (
    .vga_clk(vga_clk),
    .clrn(clrn),
    .din(dl_in),
    .dout(dl)
  );
  always_ff @(posedge vga_clk or negedge clrn)
    if (!clrn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      row_addr_q <= '0;
      col_addr_q <= '0;
      rdn_q <= 1'b1;
      st_q <= '0;
      pix_q <= '0;
      de_q <= 1'b0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      fs_q <= 1'b0;
      ls_q <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      row_addr_q <= row_addr_d;
      col_addr_q <= col_addr_d;
      rdn_q <= rdn_d;
      st_q <= st_d;
      pix_q <= pix_d;
      de_q <= de_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      fs_q <= fs_d;
      ls_q <= ls_d;
    end
  assign row_addr = row_addr_q;
  assign col_addr = col_addr_q;
  assign rdn = rdn_q;
  assign {b, g, r} = pix_q;
  assign hs = hs_q;
  assign vs = vs_q;
  assign de = de_q;
  assign frame_start = fs_q;
  assign line_start = ls_q;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: directed checks on a reduced 16x8 raster (25x13 total),
// one DUT with RD_LAT=1 active-low syncs and one with RD_LAT=3 active-high syncs.
`timescale 1ns/1ps
module tb_vga_timing_ctrl;
  localparam int HA = 16, HF = 2, HSY = 3, HB = 4;
  localparam int VA = 8, VF = 1, VSY = 2, VB = 2;
  localparam int FRAME = 25 * 13;
  logic clk = 1'b0;
  logic clrn = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
  logic pat_sel = 1'b0;
`endif
  always #5 clk = ~clk;
  logic [11:0] d1, d3, px1, px3;
  logic [2:0] row1, row3;
  logic [3:0] col1, col3, r1, g1, b1, r3, g3, b3;
  logic rdn1, rdn3, hs1, hs3, vs1, vs3, de1, de3, fs1, fs3, ls1, ls3;
  int errors = 0, checks = 0;
  vga_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
    .V_SYNC(VSY), .V_BP(VB), .HS_POL(1'b0), .VS_POL(1'b0), .CW(4), .RD_LAT(1)) u1 (
    .vga_clk(clk), .clrn(clrn), .d_in(d1),
`ifdef VGA_TEST_PATTERN_EN
    .pat_sel(pat_sel),
`endif
    .row_addr(row1), .col_addr(col1), .rdn(rdn1), .r(r1), .g(g1), .b(b1),
    .hs(hs1), .vs(vs1), .de(de1), .frame_start(fs1), .line_start(ls1));
  vga_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
    .V_SYNC(VSY), .V_BP(VB), .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .RD_LAT(3)) u3 (
    .vga_clk(clk), .clrn(clrn), .d_in(d3),
`ifdef VGA_TEST_PATTERN_EN
    .pat_sel(1'b0),
`endif
    .row_addr(row3), .col_addr(col3), .rdn(rdn3), .r(r3), .g(g3), .b(b3),
    .hs(hs3), .vs(vs3), .de(de3), .frame_start(fs3), .line_start(ls3));
  assign px1 = {b1, g1, r1};
  assign px3 = {b3, g3, r3};
  // frame-buffer model: pixel {b,g,r} = {row, ~col, col}, returned RD_LAT cycles after the address
  logic [6:0] h1;
  logic [6:0] h3 [3];
  always @(posedge clk) begin
    h1 <= {row1, col1};
    h3[0] <= {row3, col3};
    h3[1] <= h3[0];
    h3[2] <= h3[1];
  end
  function automatic logic [11:0] ramp(input logic [6:0] a);
    return {1'b0, a[6:4], ~a[3:0], a[3:0]};
  endfunction
  assign d1 = ramp(h1);
  assign d3 = ramp(h3[2]);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic rel_check(input string tag);
    int n1 = 0, n3 = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n1 == 0 && !hs1) n1 = n;
      if (n3 == 0 && hs3) n3 = n;
    end
    chk({tag, "_hs1_edges"}, n1, 3);
    chk({tag, "_hs3_edges"}, n3, 5);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int hs1n, vs1n, de1n, fs1n, ls1n, rdn1n, hs3n, vs3n, de3n, ls3n;
    int badrun, blank, run, lines3, t_hs1, t_hs3, t_rdn1, t_rdn3, k;
    logic p_hs1, p_hs3, p_rdn1, p_rdn3, p_de1, p_de3, done1, done3;
    logic [11:0] p_px3;
    repeat (4) @(negedge clk);
    chk("rst_rdn", {rdn1, rdn3}, 2'b11);
    chk("rst_rgb", {px1, px3}, 0);
    chk("rst_hs_lowpol", hs1, 1);
    chk("rst_vs_lowpol", vs1, 1);
    chk("rst_sync_highpol", {hs3, vs3}, 2'b00);
    chk("rst_de", {de1, de3}, 0);
    chk("rst_strobes", {fs1, ls1, fs3, ls3}, 0);
    chk("rst_addr", {row1, col1, row3, col3}, 0);
    clrn = 1'b1;
    rel_check("release");
    {hs1n, vs1n, de1n, fs1n, ls1n, rdn1n, hs3n, vs3n, de3n, ls3n} = '0;
    badrun = 0; blank = 0; run = 0; lines3 = -100;
    t_hs1 = -100; t_hs3 = -100; t_rdn1 = -100; t_rdn3 = -100;
    done1 = 0; done3 = 0;
    {p_hs1, p_hs3, p_rdn1, p_rdn3, p_de1, p_de3} = {hs1, hs3, rdn1, rdn3, de1, de3};
    p_px3 = px3;
    for (int t = 0; t < FRAME; t++) begin
      @(negedge clk);
      if (!hs1) hs1n++;
      if (!vs1) vs1n++;
      if (de1) de1n++;
      if (fs1) fs1n++;
      if (ls1) ls1n++;
      if (!rdn1) rdn1n++;
      if (hs3) hs3n++;
      if (vs3) vs3n++;
      if (de3) de3n++;
      if (ls3) ls3n++;
      if ((!de1 && px1 != 0) || (!de3 && px3 != 0)) blank++;
      if (de1 && !p_de1) run = 1;
      else if (de1 && run > 0) run++;
      if (!de1 && p_de1 && run > 0) begin
        if (run != HA) badrun++;
        run = 0;
      end
      if (!hs1 && p_hs1) t_hs1 = t;
      if (hs3 && !p_hs3) t_hs3 = t;
      if (!rdn1 && p_rdn1) t_rdn1 = t;
      if (!rdn3 && p_rdn3) t_rdn3 = t;
      if (ls1 && !done1) begin
        chk("hs_to_de_lat1", t - t_hs1, 7);
        chk("rdn_to_de_lat1", t - t_rdn1, 2);
        done1 = 1;
      end
      if (ls3 && !done3) begin
        chk("hs_to_de_lat3", t - t_hs3, 7);
        chk("rdn_to_de_lat3", t - t_rdn3, 4);
        done3 = 1;
      end
      if (fs1) chk("fs1_with_de_ls", {de1, ls1, px1}, {2'b11, 12'h0F0});
      if (fs3) begin
        chk("fs3_first_px", px3, 12'h0F0);
        chk("fs3_with_de_ls", {de3, ls3}, 2'b11);
        lines3 = 0;
      end
      if (ls3) lines3++;
      if (!de3 && p_de3) begin
        if (lines3 == 1) chk("line0_last_px", p_px3, 12'h00F);
        if (lines3 == VA) chk("line7_last_px", p_px3, 12'h70F);
      end
      {p_hs1, p_hs3, p_rdn1, p_rdn3, p_de1, p_de3} = {hs1, hs3, rdn1, rdn3, de1, de3};
      p_px3 = px3;
    end
    chk("hs1_low_cycles", hs1n, 39);
    chk("vs1_low_cycles", vs1n, 50);
    chk("de1_cycles", de1n, 128);
    chk("fs1_count", fs1n, 1);
    chk("ls1_count", ls1n, 8);
    chk("rdn1_low_cycles", rdn1n, 128);
    chk("hs3_high_cycles", hs3n, 39);
    chk("vs3_high_cycles", vs3n, 50);
    chk("de3_cycles", de3n, 128);
    chk("ls3_count", ls3n, 8);
    chk("bad_de_runs", badrun, 0);
    chk("rgb_outside_de", blank, 0);
    k = 0;
    for (int t = 0; t < FRAME && k < 3; t++) begin
      @(negedge clk);
      if (ls1) k++;
    end
    chk("wait_lines", k, 3);
    repeat (5) @(negedge clk);
    chk("midline_de_before", {de1, de3, rdn1}, 3'b110);
    #1 clrn = 1'b0;
    #1;
    chk("midrst_rdn", {rdn1, rdn3}, 2'b11);
    chk("midrst_rgb", {px1, px3}, 0);
    chk("midrst_sync", {hs1, vs1, hs3, vs3}, 4'b1100);
    chk("midrst_de_strobes", {de1, de3, fs1, ls1, fs3, ls3}, 0);
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    rel_check("midrst_release");
`ifdef VGA_TEST_PATTERN_EN
    begin
      int pi, bad, pn, rl;
      logic [2:0] bk;
      logic [11:0] ex;
      pat_sel = 1'b1;
      k = 0;
      for (int t = 0; t < 3 * FRAME && k < 2; t++) begin
        @(negedge clk);
        if (fs1) k++;
      end
      chk("pat_wait_frames", k, 2);
      chk("pat_first_black", px1, 12'h000);
      pi = 0; bad = 0; pn = 0; rl = 0;
      for (int t = 0; t < FRAME; t++) begin
        @(negedge clk);
        if (!rdn1) rl++;
        if (ls1) pi = 0;
        else if (de1) pi++;
        if (de1) begin
          pn++;
          bk = 3'(pi / 2);
          ex = {{4{bk[2]}}, {4{bk[1]}}, {4{bk[0]}}};
          if (px1 != ex) bad++;
          if (pi == HA - 1 && pn < HA + 1) chk("pat_last_white", px1, 12'hFFF);
        end
      end
      chk("pat_bar_mismatches", bad, 0);
      chk("pat_px_count", pn, 128);
      chk("pat_rdn_low", rl, 0);
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
